// File: rtl/if_stage_pkg.sv
`default_nettype none
//============================================================================
// Module   : if_stage_pkg
// Brief    : Shared widths, stall encodings and hold-FSM states for the
//            instruction-fetch stage.
// Revision : 1.0  initial release
//============================================================================
package if_stage_pkg;

    localparam int STALL_WD    = 6;
    localparam int BR_WD       = 33;
    localparam int IF_TO_ID_WD = 33;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    typedef enum logic [1:0] {
        IF_HOLD_RUN    = 2'd0,
        IF_HOLD_HOLD   = 2'd1,
        IF_HOLD_BUBBLE = 2'd2
    } hold_state_t;

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
//============================================================================
// Module   : if_stage_if
// Brief    : Fetch-stage bundle: stall/redirect inputs, IF->ID bus, SRAM port
//            and delivered instruction. if_adel exists only with IF_ADDR_ERR_EN.
// Revision : 1.0  initial release
//============================================================================
interface if_stage_if;
    import if_stage_pkg::*;

    logic [STALL_WD-1:0]    stall;
    logic [BR_WD-1:0]       br_bus;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic                   inst_sram_en;
    logic [3:0]             inst_sram_wen;
    logic [31:0]            inst_sram_addr;
    logic [31:0]            inst_sram_wdata;
    logic [31:0]            inst_sram_rdata;
    logic [31:0]            id_inst;
`ifdef IF_ADDR_ERR_EN
    logic                   if_adel;
`endif

    modport master (
        input  stall, br_bus, inst_sram_rdata,
        output if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
               inst_sram_wdata, id_inst
`ifdef IF_ADDR_ERR_EN
        , output if_adel
`endif
    );

    modport slave (
        output stall, br_bus, inst_sram_rdata,
        input  if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
               inst_sram_wdata, id_inst
`ifdef IF_ADDR_ERR_EN
        , input if_adel
`endif
    );

endinterface
`default_nettype wire

// File: rtl/if_inst_hold.sv
`default_nettype none
//============================================================================
// Module   : if_inst_hold
// Brief    : Keeps the instruction word aligned with the PC held in ID across
//            IF/ID stalls (HOLD) and load-use bubbles (BUBBLE).
// Revision : 1.0  initial release
//============================================================================
module if_inst_hold
    import if_stage_pkg::*;
(
    input  wire         clk,
    input  wire         rst,
    input  wire  [2:1]  stall,
    input  wire  [31:0] rdata,
    output logic [31:0] id_inst
);

    hold_state_t r_state;
    logic [31:0] r_hold_inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IF_HOLD_RUN;
            r_hold_inst <= 32'b0;
        end else begin
            case (r_state)
                IF_HOLD_RUN: begin
                    if (stall[1] == Stop && stall[2] == NoStop) begin
                        r_state <= IF_HOLD_BUBBLE;
                    end else if (stall[1] == Stop && stall[2] == Stop) begin
                        r_state     <= IF_HOLD_HOLD;
                        r_hold_inst <= rdata;
                    end
                end
                IF_HOLD_HOLD: begin
                    if (stall[1] == NoStop)
                        r_state <= IF_HOLD_RUN;
                    else if (stall[2] == NoStop)
                        r_state <= IF_HOLD_BUBBLE;
                end
                IF_HOLD_BUBBLE: begin
                    if (stall[1] == NoStop)
                        r_state <= IF_HOLD_RUN;
                end
                default: r_state <= IF_HOLD_RUN;
            endcase
        end
    end

    // RUN passes SRAM data straight through; the one-cycle SRAM latency already
    // lines it up with the ID register.
    always_comb begin
        id_inst = rdata;
        case (r_state)
            IF_HOLD_HOLD:   id_inst = r_hold_inst;
            IF_HOLD_BUBBLE: id_inst = 32'b0;
            default:        id_inst = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
//============================================================================
// Module   : if_stage
// Brief    : PC register, branch-pending latch, instruction SRAM drive and
//            IF->ID packing. Optional macro IF_ADDR_ERR_EN adds if_adel.
// Revision : 1.0  initial release
//============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  wire        clk,
    input  wire        rst,
    if_stage_if.master bus
);

    logic        r_ce;
    logic [31:0] r_pc;
    logic        r_br_pend;
    logic [31:0] r_br_tgt;

    logic        w_br_e;
    logic [31:0] w_br_addr;
    logic [31:0] w_next_pc;
    logic        w_unused_stall;

    assign w_br_e         = bus.br_bus[32];
    assign w_br_addr      = bus.br_bus[31:0];
    assign w_unused_stall = &{1'b0, bus.stall[STALL_WD-1:3]};

    // A live redirect beats a parked one; a parked one beats sequential flow.
    assign w_next_pc = w_br_e    ? w_br_addr :
                       r_br_pend ? r_br_tgt  :
                                   r_pc + PC_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_ce      <= 1'b0;
            r_br_pend <= 1'b0;
            r_br_tgt  <= 32'b0;
        end else if (bus.stall[0] == NoStop) begin
            r_pc      <= w_next_pc;
            r_ce      <= 1'b1;
            r_br_pend <= 1'b0;
        end else if (w_br_e) begin
            r_br_pend <= 1'b1;
            r_br_tgt  <= w_br_addr;
        end
    end

    assign bus.if_to_id_bus    = {r_ce, r_pc};
    assign bus.inst_sram_wen   = 4'b0;
    assign bus.inst_sram_addr  = r_pc;
    assign bus.inst_sram_wdata = 32'b0;

`ifdef IF_ADDR_ERR_EN
    logic w_adel;
    assign w_adel           = r_ce & (r_pc[1:0] != 2'b00);
    assign bus.if_adel      = w_adel;
    assign bus.inst_sram_en = r_ce & ~w_adel;
`else
    assign bus.inst_sram_en = r_ce;
`endif

    if_inst_hold u_inst_hold (
        .clk     (clk),
        .rst     (rst),
        .stall   (bus.stall[2:1]),
        .rdata   (bus.inst_sram_rdata),
        .id_inst (bus.id_inst)
    );

endmodule
`default_nettype wire
